// File: rtl/volt_to_code_pkg.sv
// ----------------------------------------------------------------------------
// volt_to_code_pkg
//   Shared constants and types for the decimal-voltage-to-code converter.
//   The ASCII sign characters and the full-scale value are also used by the
//   channel voltage formatter (code -> volts), so both sides agree on them.
// ----------------------------------------------------------------------------
package volt_to_code_pkg;

    // Sign characters on the console path
    localparam logic [7:0] ASCII_PLUS  = 8'd43;
    localparam logic [7:0] ASCII_MINUS = 8'd45;

    // Magnitude in 0.1 mV units that maps onto 2^CODE_FRAC_BITS codes (5 V)
    localparam int FULL_SCALE     = 50000;
    localparam int CODE_FRAC_BITS = 15;

    // Code and accumulator widths
    localparam int CODE_W = 16;
    localparam int BIN_W  = 17;   // holds up to 99999

    // Clamp limits: largest positive code, largest negative magnitude
    localparam logic [CODE_W-1:0] CODE_POS_MAX = 16'h7FFF;
    localparam logic [CODE_W-1:0] CODE_NEG_MAG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BCD  = 2'd1,
        DIV  = 2'd2,
        RES  = 2'd3
    } vtc_state_e;

    // True when every nibble of a BCD word is a decimal digit
    function automatic logic bcd_ok(input logic [19:0] dec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (dec[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/volt_to_code_if.sv
// ----------------------------------------------------------------------------
// volt_to_code_if
//   Request/response bundle of the converter.
//   Request  : in_valid/in_ready handshake carrying dec_in (BCD magnitude,
//              MSD in the top nibble) and sig_in (ASCII '+' or '-').
//   Response : out_valid/out_ready handshake carrying code_out (two's
//              complement), sat (result clamped) and err (bad digit/sign).
//   master : the requester/consumer side
//   slave  : the converter
// ----------------------------------------------------------------------------
interface volt_to_code_if
    import volt_to_code_pkg::*;
#(
    parameter int NDIG = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   dec_in;
    logic [7:0]          sig_in;
    logic                out_valid;
    logic                out_ready;
    logic [CODE_W-1:0]   code_out;
    logic                sat;
    logic                err;

    modport master (
        output in_valid, dec_in, sig_in, out_ready,
        input  in_ready, out_valid, code_out, sat, err
    );

    modport slave (
        input  in_valid, dec_in, sig_in, out_ready,
        output in_ready, out_valid, code_out, sat, err
    );
endinterface

// File: rtl/volt_to_code_serial_div32.sv
// ----------------------------------------------------------------------------
// serial_div32
//   Restoring divider, one quotient bit per clock, MSB first.
//   Divides a 2*DIV_W-bit dividend by a DIV_W-bit divisor and returns a
//   DIV_W-bit quotient. The caller guarantees the upper half of the dividend
//   is below the divisor, so the quotient always fits DIV_W bits.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (control only)
//     start      one-cycle pulse; dividend/divisor sampled on this cycle
//     dividend   2*DIV_W-bit unsigned dividend
//     divisor    DIV_W-bit unsigned divisor (non-zero)
//     done       one-cycle pulse DIV_W cycles after start; quotient valid
//                from then until the next start
//     quotient   DIV_W-bit unsigned result
// ----------------------------------------------------------------------------
module serial_div32 #(
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*DIV_W-1:0]   dividend,
    input  logic [DIV_W-1:0]     divisor,
    output logic                 done,
    output logic [DIV_W-1:0]     quotient
);
    localparam int CNT_W = $clog2(DIV_W);

    logic [DIV_W-1:0] rem_r;
    logic [DIV_W-1:0] lo_r;     // remaining low dividend bits, next one at MSB
    logic [DIV_W-1:0] quo_r;
    logic [DIV_W-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. Returns {qbit, rem}.
    function automatic logic [DIV_W:0] div_step(
        input logic [DIV_W-1:0] rem,
        input logic             nb,
        input logic [DIV_W-1:0] dvs
    );
        logic [DIV_W:0] t;
        t = {rem, nb};
        if (t >= {1'b0, dvs}) return {1'b1, DIV_W'(t - {1'b0, dvs})};
        else                  return {1'b0, t[DIV_W-1:0]};
    endfunction

    // The start cycle already produces the first quotient bit, so the
    // whole division takes exactly DIV_W clock edges.
    logic [DIV_W-1:0] step_rem;
    logic             step_bit;
    logic [DIV_W-1:0] step_dvs;
    logic [DIV_W:0]   step_res;

    always_comb begin
        step_rem = start ? dividend[2*DIV_W-1:DIV_W] : rem_r;
        step_bit = start ? dividend[DIV_W-1]         : lo_r[DIV_W-1];
        step_dvs = start ? divisor                   : dvs_r;
        step_res = div_step(step_rem, step_bit, step_dvs);
    end

    // Control
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                busy_r <= 1'b1;
                cnt_r  <= CNT_W'(1);
            end else if (busy_r) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(DIV_W - 1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (start) begin
            dvs_r <= divisor;
            rem_r <= step_res[DIV_W-1:0];
            lo_r  <= {dividend[DIV_W-2:0], 1'b0};
            quo_r <= {{(DIV_W-1){1'b0}}, step_res[DIV_W]};
        end else if (busy_r) begin
            rem_r <= step_res[DIV_W-1:0];
            lo_r  <= {lo_r[DIV_W-2:0], 1'b0};
            quo_r <= {quo_r[DIV_W-2:0], step_res[DIV_W]};
        end
    end

    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/volt_to_code.sv
// ----------------------------------------------------------------------------
// volt_to_code
//   Converts a signed decimal voltage (5-digit BCD magnitude in 0.1 mV units
//   plus ASCII sign) into a 16-bit two's-complement code for a +/-5 V range.
//   It inverts the formatter transfer vol = code*FULL_SCALE >> 15 with
//   round-half-up: code = round(mag * 2^15 / FULL_SCALE), clamped to 16 bits.
//   One conversion in flight; accept at edge N gives out_valid after N+23.
//   Ports:
//     clk        system clock
//     ad_reset   synchronous active-high reset
//     bus        volt_to_code_if.slave (request and response handshakes)
// ----------------------------------------------------------------------------
module volt_to_code #(
    parameter int FULL_SCALE = volt_to_code_pkg::FULL_SCALE,
    parameter int NDIG       = 5
) (
    input  logic              clk,
    input  logic              ad_reset,
    volt_to_code_if.slave     bus
);
    import volt_to_code_pkg::*;

    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int DIV_W = CODE_W;

    vtc_state_e          state, state_n;
    logic [CNT_W-1:0]    dig_cnt;
    logic                accept;
    logic                in_ready;

    logic [4*NDIG-1:0]   dec_r;
    logic                neg_r;
    logic                err_r;
    logic [BIN_W-1:0]    bin_r;
    logic [BIN_W-1:0]    bin_step;
    logic [3:0]          digit;

    logic                div_start_r;
    logic                div_done;
    logic [DIV_W-1:0]    quot;
    logic [2*DIV_W-1:0]  dividend;

    logic                out_valid_r;
    logic [CODE_W-1:0]   code_r;
    logic                sat_r;
    logic                err_o_r;
    logic [CODE_W+1:0]   result;

    // Clamp the unsigned quotient into the signed code range and apply the
    // sign. Returns {code, sat, err}. An errored request always yields 0.
    function automatic logic [CODE_W+1:0] clamp_code(
        input logic [CODE_W-1:0] q,
        input logic              neg,
        input logic              bad
    );
        logic signed [CODE_W-1:0] code_s;
        logic                     s;
        code_s = '0;
        s      = 1'b0;
        if (!bad) begin
            if (!neg) begin
                if (q > CODE_POS_MAX) begin
                    code_s = signed'(CODE_POS_MAX);
                    s      = 1'b1;
                end else begin
                    code_s = signed'(q);
                end
            end else begin
                // q == 0x8000 negates onto itself, which is exactly -32768
                if (q > CODE_NEG_MAG) begin
                    code_s = signed'(CODE_NEG_MAG);
                    s      = 1'b1;
                end else begin
                    code_s = -signed'(q);
                end
            end
        end
        return {code_s, s, bad};
    endfunction

    assign in_ready = (state == IDLE) && !out_valid_r;

    // Next-state logic
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_n = BCD;
                end
            end
            BCD: begin
                if (dig_cnt == CNT_W'(NDIG - 1)) state_n = DIV;
            end
            DIV: begin
                if (div_done) state_n = RES;
            end
            RES: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Digit-serial BCD to binary, MSD first: bin*10 + digit as (bin<<3)+(bin<<1)
    assign digit    = dec_r[4*NDIG-1 -: 4];
    assign bin_step = (bin_r << 3) + (bin_r << 1) + {{(BIN_W-4){1'b0}}, digit};

    // Adding FULL_SCALE/2 before the truncating divide gives round-half-up
    assign dividend = {bin_r, {CODE_FRAC_BITS{1'b0}}} + (2*DIV_W)'(FULL_SCALE / 2);

    assign result = clamp_code(quot, neg_r, err_r);

    // Control and registered outputs
    always_ff @(posedge clk) begin
        if (ad_reset) begin
            state       <= IDLE;
            dig_cnt     <= '0;
            div_start_r <= 1'b0;
            out_valid_r <= 1'b0;
            code_r      <= '0;
            sat_r       <= 1'b0;
            err_o_r     <= 1'b0;
        end else begin
            state       <= state_n;
            div_start_r <= (state == BCD) && (state_n == DIV);
            if (state == BCD) dig_cnt <= dig_cnt + CNT_W'(1);
            else              dig_cnt <= '0;

            if (state == RES) begin
                out_valid_r <= 1'b1;
                code_r      <= result[CODE_W+1:2];
                sat_r       <= result[1];
                err_o_r     <= result[0];
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Request capture and BCD accumulation
    always_ff @(posedge clk) begin
        if (accept) begin
            dec_r <= bus.dec_in;
            neg_r <= (bus.sig_in == ASCII_MINUS);
            err_r <= !bcd_ok(bus.dec_in) ||
                     !((bus.sig_in == ASCII_PLUS) || (bus.sig_in == ASCII_MINUS));
            bin_r <= '0;
        end else if (state == BCD) begin
            bin_r <= bin_step;
            dec_r <= dec_r << 4;
        end
    end

    serial_div32 #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (ad_reset),
        .start    (div_start_r),
        .dividend (dividend),
        .divisor  (DIV_W'(FULL_SCALE)),
        .done     (div_done),
        .quotient (quot)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.code_out  = code_r;
    assign bus.sat       = sat_r;
    assign bus.err       = err_o_r;

endmodule

// File: tb/tb_volt_to_code.sv
// ----------------------------------------------------------------------------
// tb_volt_to_code
//   Self-checking bench for volt_to_code: vector table, handshake hold,
//   reset during division and a formatter round-trip over a code sweep.
// ----------------------------------------------------------------------------
module tb_volt_to_code;
    import volt_to_code_pkg::*;

    logic clk = 1'b0;
    logic ad_reset;
    always #10 clk = ~clk;

    volt_to_code_if bus ();

    volt_to_code dut (
        .clk      (clk),
        .ad_reset (ad_reset),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] dec;
        logic [7:0]  sig;
        logic [15:0] code;
        logic        sat;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a request and return once it has been accepted (#1 after edge)
    task automatic send_req(input logic [19:0] dec, input logic [7:0] sig);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dec_in   = dec;
        bus.sig_in   = sig;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [19:0] to_bcd(input int m);
        logic [19:0] b;
        int v;
        v = m;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c, vol, mag, got, d;
        logic [7:0] sg;

        vecs[0]  = '{20'h10000, ASCII_PLUS,  16'h199A, 1'b0, 1'b0};
        vecs[1]  = '{20'h10000, ASCII_MINUS, 16'hE666, 1'b0, 1'b0};
        vecs[2]  = '{20'h50000, ASCII_MINUS, 16'h8000, 1'b0, 1'b0};
        vecs[3]  = '{20'h50000, ASCII_PLUS,  16'h7FFF, 1'b1, 1'b0};
        vecs[4]  = '{20'h00001, ASCII_PLUS,  16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{20'h00000, ASCII_MINUS, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{20'h99999, ASCII_MINUS, 16'h8000, 1'b1, 1'b0};
        vecs[7]  = '{20'h0A000, ASCII_PLUS,  16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{20'h10000, ASCII_PLUS,  16'h199A, 1'b0, 1'b0};
        vecs[9]  = '{20'h10000, 8'h30,       16'h0000, 1'b0, 1'b1};
        vecs[10] = '{20'h25000, ASCII_PLUS,  16'h4000, 1'b0, 1'b0};
        vecs[11] = '{20'h02500, ASCII_MINUS, 16'hF99A, 1'b0, 1'b0};
        vecs[12] = '{20'h99999, ASCII_PLUS,  16'h7FFF, 1'b1, 1'b0};
        vecs[13] = '{20'h00000, ASCII_PLUS,  16'h0000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dec_in    = '0;
        bus.sig_in    = '0;
        ad_reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_code",      32'(bus.code_out),  32'd0);
        chk("rst_sat",       32'(bus.sat),       32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        ad_reset = 1'b0;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            send_req(vecs[i].dec, vecs[i].sig);
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            wait_result(lat);
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'd23);
            chk($sformatf("code[%0d]", i), 32'(bus.code_out), 32'(vecs[i].code));
            chk($sformatf("sat[%0d]", i),  32'(bus.sat),      32'(vecs[i].sat));
            chk($sformatf("err[%0d]", i),  32'(bus.err),      32'(vecs[i].err));
            ack();
            chk($sformatf("ack_out_valid[%0d]", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("ack_in_ready[%0d]", i),  32'(bus.in_ready),  32'd1);
            chk($sformatf("ack_code_hold[%0d]", i), 32'(bus.code_out),  32'(vecs[i].code));
        end

        // Output held while the consumer stalls; requests meanwhile ignored
        send_req(20'h10000, ASCII_PLUS);
        wait_result(lat);
        chk("hold_latency", 32'(lat), 32'd23);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.dec_in   = 20'h20000;
            bus.sig_in   = ASCII_MINUS;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_code",      32'(bus.code_out),  32'h199A);
            chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        ack();
        chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rel_code",      32'(bus.code_out),  32'h199A);
        repeat (3) begin
            @(negedge clk);
            chk("no_ghost_accept", 32'(bus.in_ready), 32'd1);
        end

        // Reset while the divider is running
        send_req(20'h50000, ASCII_PLUS);
        repeat (10) @(posedge clk);
        @(negedge clk);
        ad_reset = 1'b1;
        @(posedge clk);
        #1;
        ad_reset = 1'b0;
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_code",      32'(bus.code_out),  32'd0);
        chk("midrst_sat",       32'(bus.sat),       32'd0);
        chk("midrst_err",       32'(bus.err),       32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_output", 32'(bus.out_valid), 32'd0);

        // Round trip through the formatter transfer vol = code*50000 >>> 15
        c = -32768;
        while (c <= 32767) begin
            vol = (c * 50000) >>> 15;
            if (vol < 0) begin mag = -vol; sg = ASCII_MINUS; end
            else         begin mag = vol;  sg = ASCII_PLUS;  end
            send_req(to_bcd(mag), sg);
            wait_result(lat);
            got = int'($signed(bus.code_out));
            d = got - c;
            checks++;
            if (d > 1 || d < -1 || bus.err) begin
                errors++;
                $display("FAIL roundtrip: code %0d recovered %0d err %0b required within 1, err 0",
                         c, got, bus.err);
            end
            ack();
            if (c == 32767)       c = 32768;
            else if (c + 1021 > 32767) c = 32767;
            else                  c = c + 1021;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
